rtc_bus_arbiter: RTL and testbench

RTC_BUS_ARBITER -- requirements
Module: rtc_bus_arbiter

---
 rtl/rtc_bus_arbiter_if.sv | 35 +++
 rtl/rtc_bus_arbiter.sv | 178 +++++++++++++++++
 tb/tb_rtc_bus_arbiter.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/rtc_bus_arbiter_if.sv
// Requester handshakes, RTC address/data bus split and chip strobes for rtc_bus_arbiter.
// The master modport is the arbiter side; the slave modport is the requester/RTC side.
interface rtc_bus_arbiter_if;
  localparam int unsigned DW = 8;

  logic          wr_req;
  logic [DW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ack;

  logic          rd_req;
  logic [DW-1:0] rd_addr;
  logic          rd_ack;
  logic [DW-1:0] rd_data;

  logic [DW-1:0] bus_din;
  logic [DW-1:0] bus_dout;
  logic          bus_oe;

  logic          CSO;
  logic          ADO;
  logic          WRO;
  logic          RDO;
  logic          busy;

  modport master (
    input  wr_req, wr_addr, wr_data, rd_req, rd_addr, bus_din,
    output wr_ack, rd_ack, rd_data, bus_dout, bus_oe, CSO, ADO, WRO, RDO, busy
  );

  modport slave (
    output wr_req, wr_addr, wr_data, rd_req, rd_addr, bus_din,
    input  wr_ack, rd_ack, rd_data, bus_dout, bus_oe, CSO, ADO, WRO, RDO, busy
  );
endinterface

// File: rtl/rtc_bus_arbiter.sv
// Round-robin arbiter between a config writer and a refresh reader sharing one RTC bus.
// Each transaction runs ADDR/A2D/DATA/RECOV phases of T_PHASE cycles, then a one-cycle DONE ack.
module rtc_bus_arbiter #(
  parameter int unsigned T_PHASE = 10
) (
  input  logic              clk,
  input  logic              reset,
  rtc_bus_arbiter_if.master bus
);
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] CNT_LAST = CW'(T_PHASE - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ADDR  = 3'd1;
  localparam logic [2:0] A2D   = 3'd2;
  localparam logic [2:0] DATA  = 3'd3;
  localparam logic [2:0] RECOV = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  logic [2:0]    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          phase_end;
  logic          grant_wr;

  // Latched transaction, captured at grant
  logic          lat_wr, lat_wr_nxt;
  logic [DW-1:0] lat_addr, lat_addr_nxt;
  logic [DW-1:0] lat_data, lat_data_nxt;
  logic          last_wr, last_wr_nxt;

  // Output registers and their next values
  logic          cso_q, ado_q, wro_q, rdo_q, oe_q, busy_q, wr_ack_q, rd_ack_q;
  logic          cso_nxt, ado_nxt, wro_nxt, rdo_nxt, oe_nxt, busy_nxt, wr_ack_nxt, rd_ack_nxt;
  logic [DW-1:0] dout_q, dout_nxt;
  logic [DW-1:0] rd_data_q, rd_data_nxt;

  // State register, latched request and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_wr    <= 1'b0;
      lat_addr  <= '0;
      lat_data  <= '0;
      last_wr   <= 1'b0;
      cso_q     <= 1'b1;
      ado_q     <= 1'b1;
      wro_q     <= 1'b1;
      rdo_q     <= 1'b1;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
      wr_ack_q  <= 1'b0;
      rd_ack_q  <= 1'b0;
      dout_q    <= '0;
      rd_data_q <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      lat_wr    <= lat_wr_nxt;
      lat_addr  <= lat_addr_nxt;
      lat_data  <= lat_data_nxt;
      last_wr   <= last_wr_nxt;
      cso_q     <= cso_nxt;
      ado_q     <= ado_nxt;
      wro_q     <= wro_nxt;
      rdo_q     <= rdo_nxt;
      oe_q      <= oe_nxt;
      busy_q    <= busy_nxt;
      wr_ack_q  <= wr_ack_nxt;
      rd_ack_q  <= rd_ack_nxt;
      dout_q    <= dout_nxt;
      rd_data_q <= rd_data_nxt;
    end
  end

  // Next state, arbitration, and outputs decoded from the state being entered
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    lat_wr_nxt   = lat_wr;
    lat_addr_nxt = lat_addr;
    lat_data_nxt = lat_data;
    last_wr_nxt  = last_wr;
    rd_data_nxt  = rd_data_q;
    grant_wr     = 1'b0;
    phase_end    = (cnt == CNT_LAST);

    unique case (state)
      IDLE: begin
        if (bus.wr_req || bus.rd_req) begin
          // On a tie the side not granted last wins
          grant_wr     = bus.wr_req && (!bus.rd_req || !last_wr);
          lat_wr_nxt   = grant_wr;
          lat_addr_nxt = grant_wr ? bus.wr_addr : bus.rd_addr;
          lat_data_nxt = grant_wr ? bus.wr_data : '0;
          last_wr_nxt  = grant_wr;
          state_nxt    = ADDR;
          cnt_nxt      = '0;
        end
      end
      ADDR, A2D, DATA, RECOV: begin
        if (phase_end) begin
          cnt_nxt = '0;
          unique case (state)
            ADDR:    state_nxt = A2D;
            A2D:     state_nxt = DATA;
            DATA:    state_nxt = RECOV;
            default: state_nxt = DONE;
          endcase
          if (state == DATA && !lat_wr) begin
            rd_data_nxt = bus.bus_din;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    cso_nxt    = 1'b1;
    ado_nxt    = 1'b1;
    wro_nxt    = 1'b1;
    rdo_nxt    = 1'b1;
    oe_nxt     = 1'b0;
    busy_nxt   = 1'b0;
    wr_ack_nxt = 1'b0;
    rd_ack_nxt = 1'b0;
    dout_nxt   = '0;

    unique case (state_nxt)
      ADDR: begin
        cso_nxt  = 1'b0;
        ado_nxt  = 1'b0;
        wro_nxt  = 1'b0;
        oe_nxt   = 1'b1;
        busy_nxt = 1'b1;
        dout_nxt = lat_addr_nxt;
      end
      A2D: begin
        oe_nxt   = 1'b1;
        busy_nxt = 1'b1;
        dout_nxt = lat_addr_nxt;
      end
      DATA: begin
        cso_nxt  = 1'b0;
        busy_nxt = 1'b1;
        if (lat_wr_nxt) begin
          wro_nxt  = 1'b0;
          oe_nxt   = 1'b1;
          dout_nxt = lat_data_nxt;
        end else begin
          rdo_nxt  = 1'b0;
        end
      end
      RECOV: busy_nxt = 1'b1;
      DONE: begin
        busy_nxt   = 1'b1;
        wr_ack_nxt = lat_wr_nxt;
        rd_ack_nxt = !lat_wr_nxt;
      end
      default: begin
      end
    endcase
  end

  assign bus.CSO      = cso_q;
  assign bus.ADO      = ado_q;
  assign bus.WRO      = wro_q;
  assign bus.RDO      = rdo_q;
  assign bus.bus_oe   = oe_q;
  assign bus.bus_dout = dout_q;
  assign bus.busy     = busy_q;
  assign bus.wr_ack   = wr_ack_q;
  assign bus.rd_ack   = rd_ack_q;
  assign bus.rd_data  = rd_data_q;
endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Directed bench for rtc_bus_arbiter: T_PHASE=2 and T_PHASE=1 instances, ack scoreboard
// filled at grant time and drained when an ack appears.
module tb_rtc_bus_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst2;
  logic rst1;

  rtc_bus_arbiter_if if2();
  rtc_bus_arbiter_if if1();

  rtc_bus_arbiter #(.T_PHASE(2)) dut2 (.clk(clk), .reset(rst2), .bus(if2.master));
  rtc_bus_arbiter #(.T_PHASE(1)) dut1 (.clk(clk), .reset(rst1), .bus(if1.master));

  typedef struct {
    bit         is_wr;
    int         ack_cyc;
    logic [7:0] rd;
  } exp_t;

  exp_t       sb2[$];
  exp_t       sb1[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;
  logic [7:0] rd_model2 = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected {CSO,ADO,WRO,RDO,oe,busy,ack,dout} in cycle k after the grant cycle
  function automatic logic [14:0] exp_vec(input int k, input int t, input bit wr,
                                          input logic [7:0] a, input logic [7:0] d);
    logic [6:0] c;
    logic [7:0] o;
    c = 7'b1111000;
    o = 8'h00;
    if (k < 1 || k > 4 * t + 1) begin
      c = 7'b1111000;
    end else if (k <= t) begin
      c = 7'b0001110; o = a;
    end else if (k <= 2 * t) begin
      c = 7'b1111110; o = a;
    end else if (k <= 3 * t) begin
      if (wr) begin c = 7'b0101110; o = d; end
      else    begin c = 7'b0110010; end
    end else if (k <= 4 * t) begin
      c = 7'b1111010;
    end else begin
      c = 7'b1111011;
    end
    return {c, o};
  endfunction

  function automatic logic [14:0] obs_vec(input bit d1, input bit wr);
    if (d1)
      return {if1.CSO, if1.ADO, if1.WRO, if1.RDO, if1.bus_oe, if1.busy,
              wr ? if1.wr_ack : if1.rd_ack, if1.bus_dout};
    return {if2.CSO, if2.ADO, if2.WRO, if2.RDO, if2.bus_oe, if2.busy,
            wr ? if2.wr_ack : if2.rd_ack, if2.bus_dout};
  endfunction

  // Advance to the next falling edge and drain scoreboards on any ack
  task automatic step();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (if2.wr_ack === 1'b1 || if2.rd_ack === 1'b1) begin
      if (sb2.size() == 0) begin
        chk("dut2_unexpected_ack", 32'({if2.wr_ack, if2.rd_ack}), 32'd0);
      end else begin
        e = sb2.pop_front();
        chk("dut2_ack_kind", 32'({if2.wr_ack, if2.rd_ack}), e.is_wr ? 32'd2 : 32'd1);
        chk("dut2_ack_cycle", 32'(cyc), 32'(e.ack_cyc));
        chk("dut2_rd_data", 32'(if2.rd_data), 32'(e.rd));
      end
    end
    if (if1.wr_ack === 1'b1 || if1.rd_ack === 1'b1) begin
      if (sb1.size() == 0) begin
        chk("dut1_unexpected_ack", 32'({if1.wr_ack, if1.rd_ack}), 32'd0);
      end else begin
        e = sb1.pop_front();
        chk("dut1_ack_kind", 32'({if1.wr_ack, if1.rd_ack}), e.is_wr ? 32'd2 : 32'd1);
        chk("dut1_ack_cycle", 32'(cyc), 32'(e.ack_cyc));
      end
    end
  endtask

  // One T_PHASE=2 transaction on dut2 with per-cycle bus checks
  task automatic txn2(input bit wr, input logic [7:0] a, input logic [7:0] d,
                      input logic [7:0] din, input int drop_k, input int din_from_k);
    exp_t e;
    if (wr) begin
      if2.wr_req = 1'b1; if2.wr_addr = a; if2.wr_data = d;
    end else begin
      if2.rd_req = 1'b1; if2.rd_addr = a;
      rd_model2 = din;
    end
    e.is_wr = wr; e.ack_cyc = cyc + 9; e.rd = rd_model2;
    sb2.push_back(e);
    chk("txn_k0", 32'(obs_vec(1'b0, wr)), 32'(exp_vec(0, 2, wr, a, d)));
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == drop_k || k == 9) begin
        if (wr) if2.wr_req = 1'b0;
        else    if2.rd_req = 1'b0;
      end
      if2.bus_din = (!wr && k >= din_from_k && k <= 6) ? din : 8'($urandom);
      chk($sformatf("txn_%s_%0h_k%0d", wr ? "wr" : "rd", a, k),
          32'(obs_vec(1'b0, wr)), 32'(exp_vec(k, 2, wr, a, d)));
    end
  endtask

  initial begin
    exp_t e;
    int   g;
    rst2 = 1'b0; rst1 = 1'b0;
    if2.wr_req = 1'b0; if2.wr_addr = 8'h00; if2.wr_data = 8'h00;
    if2.rd_req = 1'b0; if2.rd_addr = 8'h00; if2.bus_din = 8'h00;
    if1.wr_req = 1'b0; if1.wr_addr = 8'h00; if1.wr_data = 8'h00;
    if1.rd_req = 1'b0; if1.rd_addr = 8'h00; if1.bus_din = 8'h00;

    // Reset state
    step(); step();
    chk("reset_dut2_vec", 32'(obs_vec(1'b0, 1'b1)), 32'(15'b1111000_00000000));
    chk("reset_dut2_rdack", 32'(if2.rd_ack), 32'd0);
    chk("reset_dut2_rd_data", 32'(if2.rd_data), 32'd0);
    chk("reset_dut1_vec", 32'(obs_vec(1'b1, 1'b0)), 32'(15'b1111000_00000000));
    rst2 = 1'b1;
    step();
    chk("idle_no_req", 32'(obs_vec(1'b0, 1'b0)), 32'(15'b1111000_00000000));

    // Write, read, write (rd_data must survive it), read dropped in A2D with late bus data
    txn2(1'b1, 8'h21, 8'h45, 8'h00, 0, 0);
    chk("rd_data_after_write", 32'(if2.rd_data), 32'd0);
    txn2(1'b0, 8'h22, 8'h00, 8'h37, 0, 5);
    chk("rd_data_after_read", 32'(if2.rd_data), 32'h37);
    txn2(1'b1, 8'h50, 8'h66, 8'h00, 0, 0);
    chk("rd_data_held_by_write", 32'(if2.rd_data), 32'h37);
    txn2(1'b0, 8'h7E, 8'h00, 8'h9C, 3, 6);
    chk("rd_data_after_drop", 32'(if2.rd_data), 32'h9C);

    // Tie after reset: no grant during reset, then write, read, write
    rst2 = 1'b0;
    if2.wr_req = 1'b1; if2.wr_addr = 8'h31; if2.wr_data = 8'hA5;
    if2.rd_req = 1'b1; if2.rd_addr = 8'h32; if2.bus_din = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("no_grant_in_reset", 32'({if2.busy, if2.CSO, if2.bus_oe}), 32'b010);
    end
    rd_model2 = 8'h00;
    rst2 = 1'b1;
    g = cyc;
    e.is_wr = 1'b1; e.ack_cyc = g + 9;  e.rd = 8'h00; sb2.push_back(e);
    e.is_wr = 1'b0; e.ack_cyc = g + 19; e.rd = 8'h5A; sb2.push_back(e);
    e.is_wr = 1'b1; e.ack_cyc = g + 29; e.rd = 8'h5A; sb2.push_back(e);
    rd_model2 = 8'h5A;
    for (int k = 1; k <= 31; k++) begin
      step();
      if (k == 1)  chk("tie_grant1_wr", 32'({if2.WRO, if2.bus_dout}), 32'h031);
      if (k == 11) chk("tie_grant2_rd", 32'({if2.WRO, if2.bus_dout}), 32'h032);
      if (k == 21) chk("tie_grant3_wr", 32'({if2.WRO, if2.bus_dout}), 32'h031);
      if (k == 29) begin if2.wr_req = 1'b0; if2.rd_req = 1'b0; end
      if (k == 31) chk("tie_idle_after", 32'(if2.busy), 32'd0);
    end

    // Reset in DATA of a write aborts it; held request is re-granted after release
    if2.wr_req = 1'b1; if2.wr_addr = 8'h44; if2.wr_data = 8'h55;
    e.is_wr = 1'b1; e.ack_cyc = cyc + 9; e.rd = rd_model2; sb2.push_back(e);
    for (int k = 1; k <= 5; k++) step();
    chk("abort_in_data", 32'({if2.CSO, if2.WRO, if2.bus_dout}), 32'h055);
    rst2 = 1'b0;
    void'(sb2.pop_back());
    step();
    chk("abort_idle", 32'(obs_vec(1'b0, 1'b1)), 32'(15'b1111000_00000000));
    rd_model2 = 8'h00;
    rst2 = 1'b1;
    e.is_wr = 1'b1; e.ack_cyc = cyc + 9; e.rd = 8'h00; sb2.push_back(e);
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 1) chk("regrant_addr", 32'({if2.CSO, if2.ADO, if2.bus_dout}), 32'h044);
      if (k == 9) if2.wr_req = 1'b0;
    end

    // T_PHASE=1 with continuous write: 5-cycle transaction, ack every 6 cycles
    if1.wr_req = 1'b1; if1.wr_addr = 8'h11; if1.wr_data = 8'h99;
    rst1 = 1'b1;
    g = cyc;
    for (int i = 0; i < 3; i++) begin
      e.is_wr = 1'b1; e.ack_cyc = g + 5 + 6 * i; e.rd = 8'h00; sb1.push_back(e);
    end
    for (int k = 1; k <= 19; k++) begin
      step();
      if (k <= 6)
        chk($sformatf("t1_k%0d", k), 32'(obs_vec(1'b1, 1'b1)),
            32'(exp_vec(k, 1, 1'b1, 8'h11, 8'h99)));
      if (k == 17) if1.wr_req = 1'b0;
    end

    chk("sb2_drained", 32'(sb2.size()), 32'd0);
    chk("sb1_drained", 32'(sb1.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
